// File: rtl/mips_pkg.sv
// Shared widths and well-known register numbers
// for the MIPS five-stage pipeline.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [4:0] REG_ZERO = 5'd0;
    // Link register written by jal.
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_rport.sv
// One combinational read port: zero check, WB bypass,
// then storage lookup.
module reg_file_rport
    import mips_pkg::*;
#(
    parameter int P_DATA_W   = mips_pkg::DATA_W,
    parameter int P_ADDR_W   = mips_pkg::ADDR_W,
    parameter int P_NUM_REGS = mips_pkg::NUM_REGS
) (
    input  logic [P_ADDR_W-1:0]                 addr,
    input  logic                                byp_en,
    input  logic [P_ADDR_W-1:0]                 byp_addr,
    input  logic [P_DATA_W-1:0]                 byp_data,
    input  logic [P_NUM_REGS-1:0][P_DATA_W-1:0] regs,
    output logic [P_DATA_W-1:0]                 data
);

    always_comb begin
        data = '0;
        if (addr == REG_ZERO) begin
            data = '0;
        end else if (byp_en && (byp_addr == addr)) begin
            data = byp_data;
        end else begin
            data = regs[addr];
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32x32 MIPS register file: two combinational read ports,
// one WB write port with same-cycle bypass.
module reg_file
    import mips_pkg::*;
#(
    parameter int P_DATA_W = mips_pkg::DATA_W,
    parameter int P_ADDR_W = mips_pkg::ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [P_ADDR_W-1:0] rs_addr,
    input  logic [P_ADDR_W-1:0] rt_addr,
    output logic [P_DATA_W-1:0] rs_data,
    output logic [P_DATA_W-1:0] rt_data,
    input  logic                wr_en,
    input  logic [P_ADDR_W-1:0] wr_addr,
    input  logic [P_DATA_W-1:0] wr_data
);

    localparam int P_NUM_REGS = 2 ** P_ADDR_W;

    logic [P_DATA_W-1:0] regs_q [1:P_NUM_REGS-1];
    logic [P_DATA_W-1:0] regs_d [1:P_NUM_REGS-1];

    logic [P_NUM_REGS-1:0][P_DATA_W-1:0] store;
    logic                                byp_en;

    // wr_addr is only looked at under wr_en, so an
    // unknown address on an idle port cannot corrupt storage.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != REG_ZERO)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < P_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        store[0] = '0;
        for (int i = 1; i < P_NUM_REGS; i++) begin
            store[i] = regs_q[i];
        end
    end

    // Bypass is killed in reset so both ports read zero.
    assign byp_en = wr_en & rst_n;

    reg_file_rport #(
        .P_DATA_W  (P_DATA_W),
        .P_ADDR_W  (P_ADDR_W),
        .P_NUM_REGS(P_NUM_REGS)
    ) u_rs (
        .addr    (rs_addr),
        .byp_en  (byp_en),
        .byp_addr(wr_addr),
        .byp_data(wr_data),
        .regs    (store),
        .data    (rs_data)
    );

    reg_file_rport #(
        .P_DATA_W  (P_DATA_W),
        .P_ADDR_W  (P_ADDR_W),
        .P_NUM_REGS(P_NUM_REGS)
    ) u_rt (
        .addr    (rt_addr),
        .byp_en  (byp_en),
        .byp_addr(wr_addr),
        .byp_data(wr_data),
        .regs    (store),
        .data    (rt_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed table,
// reset sequences and a randomized model comparison.
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks;
    int failures;

    logic [31:0] mem [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [13];

    reg_file dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h want %08h",
                     name, act, exp);
        end
    endtask

    // Reference read: zero reg, then live WB write, then storage.
    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return mem[a];
    endfunction

    function automatic vec_t mk(input logic we,
                                input logic [4:0] wa,
                                input logic [31:0] wd,
                                input logic [4:0] ra,
                                input logic [4:0] rb,
                                input logic [31:0] ea,
                                input logic [31:0] eb);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.ra = ra; v.rb = rb;
        v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic tick_model();
        @(posedge clk);
        if (rst_n && wr_en && wr_addr != 5'd0)
            mem[wr_addr] = wr_data;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        foreach (mem[i]) mem[i] = 32'd0;

        vecs[0]  = mk(1, 8,  32'hDEADBEEF, 8, 31,
                      32'hDEADBEEF, 32'h0);
        vecs[1]  = mk(1, 31, 32'h00000001, 8, 31,
                      32'hDEADBEEF, 32'h1);
        vecs[2]  = mk(0, 0,  32'h0, 8, 31,
                      32'hDEADBEEF, 32'h1);
        vecs[3]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,
                      32'h0, 32'h0);
        vecs[4]  = mk(0, 0,  32'h0, 0, 8,
                      32'h0, 32'hDEADBEEF);
        vecs[5]  = mk(1, 5,  32'h11111111, 5, 5,
                      32'h11111111, 32'h11111111);
        vecs[6]  = mk(0, 5,  32'h22222222, 5, 5,
                      32'h11111111, 32'h11111111);
        vecs[7]  = mk(1, 5,  32'h22222222, 5, 5,
                      32'h22222222, 32'h22222222);
        vecs[8]  = mk(0, 0,  32'h0, 5, 5,
                      32'h22222222, 32'h22222222);
        vecs[9]  = mk(1, 9,  32'hAAAA0001, 9, 8,
                      32'hAAAA0001, 32'hDEADBEEF);
        vecs[10] = mk(1, 9,  32'hBBBB0002, 8, 9,
                      32'hDEADBEEF, 32'hBBBB0002);
        vecs[11] = mk(0, 9,  32'hCCCC0003, 9, 9,
                      32'hBBBB0002, 32'hBBBB0002);
        vecs[12] = mk(1, 10, 32'h0C0C0C0C, 10, 0,
                      32'h0C0C0C0C, 32'h0);

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rs_addr = '0;
        rt_addr = '0;

        // In reset every address reads zero, even with a
        // matching write presented (bypass suppressed).
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            wr_en   = 1'b1;
            wr_addr = 5'(a);
            wr_data = 32'hFFFF0000 | 32'(a);
            #1;
            check("rst_rs", rs_data, 32'd0);
            check("rst_rt", rt_data, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(a);
            #0.1;
            check("post_rst_rs", rs_data, 32'd0);
            check("post_rst_rt", rt_data, 32'd0);
        end

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            rs_addr = vecs[i].ra;
            rt_addr = vecs[i].rb;
            #1;
            check($sformatf("vec%0d_rs", i),
                  rs_data, vecs[i].exp_a);
            check($sformatf("vec%0d_rt", i),
                  rt_data, vecs[i].exp_b);
            tick_model();
        end

        // Fill r1..r31 with their index.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = 5'(a);
            wr_data = 32'(a);
            tick_model();
        end
        @(negedge clk);
        wr_en = 1'b0;
        rs_addr = 5'd7;
        rt_addr = 5'd31;
        #1;
        check("fill_r7", rs_data, 32'd7);
        check("fill_r31", rt_data, 32'd31);

        // Async reset between edges clears storage at once.
        #1;
        rst_n = 1'b0;
        #0.5;
        check("async_r7", rs_data, 32'd0);
        check("async_r31", rt_data, 32'd0);
        foreach (mem[i]) mem[i] = 32'd0;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'h33333333;
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        #0.5;
        check("rstwr_byp_rs", rs_data, 32'd0);
        check("rstwr_byp_rt", rt_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rstwr_lost", rs_data, 32'd0);
        rs_addr = 5'd15;
        rt_addr = 5'd1;
        #1;
        check("async_r15", rs_data, 32'd0);
        check("async_r1", rt_data, 32'd0);

        // First write after release lands on the next edge.
        wr_en   = 1'b1;
        wr_addr = 5'd1;
        wr_data = 32'h5A5A5A5A;
        tick_model();
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        check("rel_first_wr", rt_data, 32'h5A5A5A5A);

        // Idle port with unknown address must not write.
        wr_addr = 5'bx;
        tick_model();
        @(negedge clk);
        wr_addr = 5'd0;
        #1;
        check("x_addr_r1", rt_data, 32'h5A5A5A5A);

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            rs_addr = ($urandom_range(0, 3) == 0) ?
                      wr_addr : 5'($urandom_range(0, 31));
            rt_addr = ($urandom_range(0, 3) == 0) ?
                      wr_addr : 5'($urandom_range(0, 31));
            #1;
            check("rnd_rs", rs_data, model_rd(rs_addr));
            check("rnd_rt", rt_data, model_rd(rt_addr));
            tick_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
